// File: rtl/regdump_serializer.sv
// regdump_serializer: snapshots a packed register file on Trigger and streams
// it out as a byte frame: 0xA5, {index, data[15:8], data[7:0]} per register,
// then an 8-bit checksum of every byte between header and checksum.
//
// Handshake: a byte transfers on a rising edge where ByteValid && ByteReady.
// ByteValid and ByteOut come only from registered state, so there is no
// combinational path from ByteReady; once valid, a byte holds until accepted.
module regdump_serializer #(
  parameter int NUM_REGS = 8
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [NUM_REGS*16-1:0]  DebugData,
  input  logic                    Trigger,
  output logic [7:0]              ByteOut,
  output logic                    ByteValid,
  input  logic                    ByteReady,
  output logic                    Busy,
  output logic                    Done,
  output logic [7:0]              DropCount,
  output logic [2:0]              DbgState
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_IDX  = 3'd2,
    S_HI   = 3'd3,
    S_LO   = 3'd4,
    S_CSUM = 3'd5
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

  state_t                    state_q, state_d;
  logic [7:0]                idx_q, idx_d;
  logic [7:0]                csum_q, csum_d;
  logic [NUM_REGS*16-1:0]    snap_q, snap_d;
  logic                      done_q, done_d;
  logic [7:0]                drop_q, drop_d;
  logic [15:0]               cur_reg;
  logic                      hs;

  assign hs = (state_q != S_IDLE) && ByteReady;

  // Select the snapshot register addressed by the current index.
  always_comb begin
    cur_reg = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx_q == 8'(k)) cur_reg = snap_q[k*16 +: 16];
    end
  end

  // State register and all datapath registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic: frame sequencing, checksum accumulation, drop counting.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    drop_d  = drop_q;

    // Any trigger while a frame is in flight (CSUM accept cycle included) is dropped.
    if ((state_q != S_IDLE) && Trigger && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (Trigger) begin
          snap_d  = DebugData;
          idx_d   = '0;
          csum_d  = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (hs) state_d = S_IDX;
      end
      S_IDX: begin
        if (hs) begin
          csum_d  = csum_q + idx_q;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (hs) begin
          csum_d  = csum_q + cur_reg[15:8];
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (hs) begin
          csum_d = csum_q + cur_reg[7:0];
          if (idx_q == LAST_IDX) begin
            state_d = S_CSUM;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_IDX;
          end
        end
      end
      S_CSUM: begin
        if (hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte mux driven purely by registered state.
  always_comb begin
    ByteOut = 8'h00;
    case (state_q)
      S_HDR:   ByteOut = 8'hA5;
      S_IDX:   ByteOut = idx_q;
      S_HI:    ByteOut = cur_reg[15:8];
      S_LO:    ByteOut = cur_reg[7:0];
      S_CSUM:  ByteOut = csum_q;
      default: ByteOut = 8'h00;
    endcase
  end

  assign ByteValid = (state_q != S_IDLE);
  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign DropCount = drop_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_regdump_serializer.sv
// Bench for regdump_serializer: table of frame scenarios plus hand-written
// sequences for drop saturation and mid-frame reset.
module tb_regdump_serializer;

  localparam int NR = 8;

  logic             clk;
  logic             rst_n;
  logic [NR*16-1:0] debug_data;
  logic             trigger;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             busy;
  logic             done;
  logic [7:0]       drop_count;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drop = 0;
  logic [7:0] exp_q[$];

  regdump_serializer #(.NUM_REGS(NR)) dut (
    .Clk(clk), .Rst_n(rst_n), .DebugData(debug_data), .Trigger(trigger),
    .ByteOut(byte_out), .ByteValid(byte_valid), .ByteReady(byte_ready),
    .Busy(busy), .Done(done), .DropCount(drop_count), .DbgState(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    trigger    = 1'b0;
    byte_ready = 1'b0;
    debug_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_drop = 0;
  endtask

  // One frame: optional trigger pulse, byte stream checked against exp_q,
  // optional mid-frame triggers with DebugData corruption, optional trigger in Done cycle.
  task automatic run_frame(input logic [NR*16-1:0] data, input int ready_mode,
                           input logic [7:0] exp_csum, input int mid_trig,
                           input bit pre_trig, input bit chain);
    int   cyc;
    int   pulses;
    bit   hold;
    logic [7:0] held;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < NR; k++) begin
      exp_q.push_back(8'(k));
      exp_q.push_back(data[k*16+8 +: 8]);
      exp_q.push_back(data[k*16 +: 8]);
    end
    exp_q.push_back(exp_csum);
    if (!pre_trig) begin
      debug_data = data;
      trigger    = 1'b1;
      @(negedge clk);
    end
    trigger = 1'b0;
    check("first_byte_valid", {31'b0, byte_valid}, 32'd1);
    check("busy_in_frame", {31'b0, busy}, 32'd1);
    cyc = 0; pulses = 0; hold = 1'b0; held = 8'h00;
    while (exp_q.size() != 0 && cyc < 2000) begin
      trigger = 1'b0;
      if (mid_trig > pulses && cyc == 3 + 4 * pulses) begin
        trigger    = 1'b1;
        debug_data = ~data;
        pulses++;
      end
      byte_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (hold) begin
        if (byte_valid !== 1'b1 || byte_out !== held) begin
          n_checks++; n_fail++;
          $display("FAIL hold_stable: valid=%0b out=0x%0h expected held 0x%0h", byte_valid, byte_out, held);
        end
      end
      if (byte_valid && byte_ready) begin
        check("stream_byte", {24'b0, byte_out}, {24'b0, exp_q.pop_front()});
        hold = 1'b0;
      end else if (byte_valid) begin
        hold = 1'b1;
        held = byte_out;
      end
      @(negedge clk);
      cyc++;
    end
    trigger    = 1'b0;
    byte_ready = 1'b0;
    check("frame_timeout", cyc < 2000 ? 32'd0 : 32'd1, 32'd0);
    check("done_pulse", {31'b0, done}, 32'd1);
    check("busy_after", {31'b0, busy}, 32'd0);
    check("valid_after", {31'b0, byte_valid}, 32'd0);
    exp_drop = (exp_drop + mid_trig > 255) ? 255 : exp_drop + mid_trig;
    check("drop_count", {24'b0, drop_count}, exp_drop);
    if (chain) begin
      trigger = 1'b1;
      @(negedge clk);
      check("chain_hdr", {23'b0, byte_valid, byte_out}, {23'b0, 1'b1, 8'hA5});
    end else begin
      @(negedge clk);
      check("done_one_cycle", {31'b0, done}, 32'd0);
    end
  endtask

  typedef struct {
    logic [NR*16-1:0] data;
    int               ready_mode;
    logic [7:0]       csum;
    int               mid_trig;
    bit               chain;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cnt;
    vecs[0] = '{128'h0, 0, 8'h1C, 0, 1'b0};
    vecs[1] = '{128'h1234, 0, 8'h62, 0, 1'b0};
    vecs[2] = '{128'h0707_0606_0505_0404_0303_0202_0101_0000, 1, 8'h54, 0, 1'b0};
    vecs[3] = '{128'h1234, 1, 8'h62, 0, 1'b0};
    vecs[4] = '{{128{1'b1}}, 0, 8'h0C, 3, 1'b0};
    vecs[5] = '{128'h0, 0, 8'h1C, 0, 1'b1};
    vecs[6] = '{128'h0, 1, 8'h1C, 0, 1'b0};

    apply_reset();
    check("rst_valid", {31'b0, byte_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_drop", {24'b0, drop_count}, 32'd0);
    check("rst_byte", {24'b0, byte_out}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].data, vecs[i].ready_mode, vecs[i].csum, vecs[i].mid_trig,
                (i > 0) ? vecs[i-1].chain : 1'b0, vecs[i].chain);
    end

    // Drop counter saturation: start a stalled frame, hold Trigger for 300 more cycles.
    debug_data = 128'h0707_0606_0505_0404_0303_0202_0101_0000;
    byte_ready = 1'b0;
    trigger    = 1'b1;
    repeat (301) @(negedge clk);
    trigger = 1'b0;
    check("drop_saturate", {24'b0, drop_count}, 32'd255);

    // Advance to the HI byte of reg 3 (11 bytes accepted), then reset.
    cnt = 0;
    while (cnt < 11 && cnt < 100) begin
      byte_ready = 1'b1;
      if (byte_valid) cnt++;
      @(negedge clk);
    end
    byte_ready = 1'b0;
    check("at_hi3_state", {29'b0, dbg_state}, 32'd3);
    check("at_hi3_byte", {24'b0, byte_out}, 32'h03);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, byte_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_drop", {24'b0, drop_count}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_drop = 0;
    @(negedge clk);
    run_frame(128'h1234, 0, 8'h62, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
